// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler sharing a bank of envelope
// instances between note-on/note-off events.
// Build option: define VOICE_STEAL_EN to steal the oldest held voice when all
// voices are held. Without it, such a note-on is discarded and drop_o pulses.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WIDTH = 7
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             event_valid_i,
  output logic                             event_ready_o,
  input  logic                             event_on_i,
  input  logic [NOTE_WIDTH-1:0]            event_note_i,
  input  logic [NUM_VOICES-1:0]            env_idle_i,
  output logic [NUM_VOICES-1:0]            gate_o,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0] voice_note_o,
  output logic                             steal_o,
  output logic                             drop_o
);

  localparam int IW = $clog2(NUM_VOICES);

  typedef logic [IW-1:0]         idx_t;
  typedef logic [NOTE_WIDTH-1:0] note_t;

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } vstate_e;

  // Control FSM: RETRIG is the single cycle where a retriggered voice has
  // its gate held low and no new event may be accepted.
  typedef enum logic {
    CTL_RUN    = 1'b0,
    CTL_RETRIG = 1'b1
  } ctl_e;

  vstate_e vstate_q [NUM_VOICES];
  vstate_e vstate_d [NUM_VOICES];
  idx_t    rank_q   [NUM_VOICES];
  idx_t    rank_d   [NUM_VOICES];
  note_t   note_q   [NUM_VOICES];
  note_t   note_d   [NUM_VOICES];

  logic [NUM_VOICES-1:0] gate_q, gate_d;
  ctl_e                  ctl_q, ctl_d;
  idx_t                  retrig_q, retrig_d;
  logic                  ready_q;

`ifdef VOICE_STEAL_EN
  logic steal_q, steal_d;
  logic any_held;
  idx_t held_idx;
`else
  logic drop_q, drop_d;
`endif

  // Candidate voices for the incoming event
  logic hit, any_free, any_rel;
  idx_t hit_idx, free_idx, rel_idx;

  // Allocation decision for this cycle
  logic accept, alloc, alloc_retrig;
  idx_t alloc_idx;

  // Candidate search: held voice with the event note, lowest free voice,
  // oldest releasing voice and (with stealing) oldest held voice.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    any_rel  = 1'b0;
    rel_idx  = '0;
`ifdef VOICE_STEAL_EN
    any_held = 1'b0;
    held_idx = '0;
`endif
    // Descending scan so the lowest matching index is the one kept.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (vstate_q[v] == V_HELD && note_q[v] == event_note_i) begin
        hit     = 1'b1;
        hit_idx = idx_t'(v);
      end
      if (vstate_q[v] == V_FREE) begin
        any_free = 1'b1;
        free_idx = idx_t'(v);
      end
    end
    // Oldest means largest age rank; ranks are unique so there are no ties.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vstate_q[v] == V_RELEASING && (!any_rel || rank_q[v] > rank_q[rel_idx])) begin
        any_rel = 1'b1;
        rel_idx = idx_t'(v);
      end
`ifdef VOICE_STEAL_EN
      if (vstate_q[v] == V_HELD && (!any_held || rank_q[v] > rank_q[held_idx])) begin
        any_held = 1'b1;
        held_idx = idx_t'(v);
      end
`endif
    end
  end

  // Next-state logic: idle retirement, RETRIG completion, event handling
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results; only the clocked block uses non-blocking '<='.
    vstate_d     = vstate_q;
    rank_d       = rank_q;
    note_d       = note_q;
    gate_d       = gate_q;
    ctl_d        = CTL_RUN;
    retrig_d     = retrig_q;
    alloc        = 1'b0;
    alloc_retrig = 1'b0;
    alloc_idx    = '0;
`ifdef VOICE_STEAL_EN
    steal_d      = 1'b0;
`else
    drop_d       = 1'b0;
`endif

    // Releasing voices whose envelope reached zero go back to the free pool.
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vstate_q[v] == V_RELEASING && env_idle_i[v]) begin
        vstate_d[v] = V_FREE;
      end
    end

    // Second RETRIG cycle: raise the gate again.
    if (ctl_q == CTL_RETRIG) begin
      gate_d[retrig_q] = 1'b1;
    end

    accept = event_valid_i && ready_q;

    if (accept) begin
      if (event_on_i) begin
        if (hit) begin
          alloc        = 1'b1;
          alloc_retrig = 1'b1;
          alloc_idx    = hit_idx;
        end else if (any_free) begin
          alloc     = 1'b1;
          alloc_idx = free_idx;
        end else if (any_rel) begin
          alloc     = 1'b1;
          alloc_idx = rel_idx;
        end else begin
`ifdef VOICE_STEAL_EN
          alloc        = 1'b1;
          alloc_retrig = 1'b1;
          alloc_idx    = held_idx;
          steal_d      = 1'b1;
`else
          drop_d = 1'b1;
`endif
        end
      end else if (hit) begin
        vstate_d[hit_idx] = V_RELEASING;
        gate_d[hit_idx]   = 1'b0;
      end
    end

    // Allocation overrides an idle retirement of the same voice. Every
    // note-on assignment, retrigger included, makes the voice the newest.
    if (alloc) begin
      vstate_d[alloc_idx] = V_HELD;
      note_d[alloc_idx]   = event_note_i;
      gate_d[alloc_idx]   = !alloc_retrig;
      for (int u = 0; u < NUM_VOICES; u++) begin
        if (rank_q[u] < rank_q[alloc_idx]) begin
          rank_d[u] = rank_q[u] + 1'b1;
        end
      end
      rank_d[alloc_idx] = '0;
      if (alloc_retrig) begin
        ctl_d    = CTL_RETRIG;
        retrig_d = alloc_idx;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the per-voice arrays are ordinary flops rather than a RAM, so
      // every entry is cleared; ranks must restart as a valid permutation.
      for (int v = 0; v < NUM_VOICES; v++) begin
        vstate_q[v] <= V_FREE;
        rank_q[v]   <= idx_t'(v);
        note_q[v]   <= '0;
      end
      gate_q   <= '0;
      ctl_q    <= CTL_RUN;
      retrig_q <= '0;
      ready_q  <= 1'b1;
`ifdef VOICE_STEAL_EN
      steal_q  <= 1'b0;
`else
      drop_q   <= 1'b0;
`endif
    end else begin
      vstate_q <= vstate_d;
      rank_q   <= rank_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      ctl_q    <= ctl_d;
      retrig_q <= retrig_d;
      ready_q  <= (ctl_d == CTL_RUN);
`ifdef VOICE_STEAL_EN
      steal_q  <= steal_d;
`else
      drop_q   <= drop_d;
`endif
    end
  end

  // Flatten per-voice notes onto the output bus
  always_comb begin
    voice_note_o = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_note_o[v*NOTE_WIDTH +: NOTE_WIDTH] = note_q[v];
    end
  end

  assign gate_o        = gate_q;
  assign event_ready_o = ready_q;

`ifdef VOICE_STEAL_EN
  assign steal_o = steal_q;
  assign drop_o  = 1'b0;
`else
  assign steal_o = 1'b0;
  assign drop_o  = drop_q;
`endif

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler that shares a bank of `adsr_envelope` instances between incoming note events. It accepts note-on/note-off events over a valid/ready handshake, assigns each note-on to a free, releasing or stolen voice, and drives each voice's envelope gate (`valid_i` of `adsr_envelope`) and note number. It sits between the event front end (MIDI/sequencer) and the per-voice oscillator/envelope datapath.

## Interface
- `NUM_VOICES`, 4: number of envelope/voice instances managed; 2..16.
- `NOTE_WIDTH`, 7: note number width.
- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous, active-high reset.
- `event_valid_i` input 1: event present.
- `event_ready_o` output 1: allocator can accept an event this cycle.
- `event_on_i` input 1: 1 = note-on, 0 = note-off.
- `event_note_i` input NOTE_WIDTH: note number of the event.
- `env_idle_i` input NUM_VOICES: per-voice envelope-at-zero flag from each `adsr_envelope` instance.
- `gate_o` output NUM_VOICES: per-voice gate; drives envelope `valid_i`.
- `voice_note_o` output NUM_VOICES*NOTE_WIDTH: voice v's note in bits [v*NOTE_WIDTH +: NOTE_WIDTH].
- `steal_o` output 1: one-cycle pulse when a held voice is stolen.
- `drop_o` output 1: one-cycle pulse when a note-on is discarded.

## Operation
- Per-voice state: FREE, HELD (gate high), RELEASING (gate low, envelope not yet idle). There is also a global RETRIG flag.
- Age rank per voice, 0 (newest) .. NUM_VOICES-1 (oldest), always a permutation. On allocation of voice v, every voice with rank < rank[v] increments, and v takes rank 0. Reset ranks: voice i = i.
- Note-on for note n is handled by the first matching rule:
  1. A HELD voice already has note n: retrigger that voice (RETRIG sequence).
  2. Otherwise, allocate the lowest-index FREE voice.
  3. Otherwise, allocate the oldest RELEASING voice (gate rises next cycle).
  4. Otherwise, steal the oldest HELD voice (RETRIG sequence) and pulse `steal_o`.
- RETRIG sequence: in cycle 1, the gate goes low and the note updates. In cycle 2, the gate goes high. `event_ready_o` is low during cycle 1.
- Note-off for note n: the HELD voice with note n becomes RELEASING and its gate drops. If there is no match, the event is accepted and ignored.
- A RELEASING voice becomes FREE in the cycle after `env_idle_i[v]` is sampled high. `voice_note_o` keeps the last note.
- `env_idle_i` is ignored for HELD and FREE voices.
- Only one event is processed per cycle. Idle transitions proceed in parallel with events.
- If a RELEASING voice is allocated in the same cycle its `env_idle_i` is high, the allocation wins: the voice becomes HELD.

## Timing
- Reset values: `gate_o`=0, `voice_note_o`=0, all voices FREE, `event_ready_o`=1, `steal_o`=0, `drop_o`=0.
- An event is accepted on a rising edge with `event_valid_i && event_ready_o`.
- `event_ready_o` is registered. It is low only in RETRIG cycle 1.
- Normal note-on and note-off: `gate_o` and `voice_note_o` update 1 cycle after acceptance.
- Retrigger/steal: gate is low at +1 and high at +2. `steal_o` pulses at +1.
- Back-to-back events at full rate are allowed except when they would follow a RETRIG cycle.
- `rst_i` mid-operation returns everything to reset values on the next edge. Any in-flight RETRIG is abandoned.

## Configuration
- `VOICE_STEAL_EN` defined: rule 4 is active as described.
- `VOICE_STEAL_EN` undefined: when every voice is HELD (and rule 1 does not apply), the note-on is accepted and discarded, and `drop_o` pulses at +1.
  - `steal_o` is tied to 0.
  - Rules 1–3 and retrigger are unchanged.
- With the macro defined, `drop_o` is tied to 0.

## Test plan
All scenarios use NUM_VOICES=4.
- **Reset:** assert `rst_i` 5 cycles -> `gate_o`=4'b0000, `event_ready_o`=1, `voice_note_o`=0.
- **Fill then release:**
  - Note-on 60, 62, 64 on consecutive cycles -> `gate_o`=0001, 0011, 0111 on successive cycles; voice notes 60/62/64.
  - Note-off 62 -> `gate_o`=0101.
  - Then `env_idle_i[1]`=1 -> voice 1 FREE one cycle later.
- **Reuse of releasing voice:** voices 0..3 hold 60,62,64,65. Note-off 60, then note-off 62, then note-on 67 before either is idle -> voice 0 (oldest releasing) gets 67; `gate_o`=1101.
- **Steal (macro on):** four held notes 60,62,64,65 allocated in that order. Note-on 70 ->
  - `steal_o` pulses, voice 0 gate 0 at +1 and 1 at +2, `voice_note_o[0]`=70.
  - `event_ready_o`=0 at +1.
- **Drop (macro off):** same setup, note-on 70 -> `drop_o` pulses at +1, `gate_o` stays 1111, notes unchanged.
- **Edge cases:**
  - Note-on 60 while 60 is held -> that voice retriggers (0 then 1).
  - Note-off 99 unmatched -> no change.
  - `rst_i` during a RETRIG cycle -> all outputs at reset values next edge.
